// File: rtl/gen_window_sum_if.sv
// Caller-side and upstream-side handshake bundle for the window-sum generator stage.
// The slave modport is the stage itself; the master modport is whoever drives it.
interface gen_window_sum_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             ready;
    logic             valid;
    logic             done;
    logic [WIDTH-1:0] out0;
    logic [WIDTH-1:0] out1;

    logic             up_start;
    logic             up_ready;
    logic             up_valid;
    logic             up_done;
    logic [WIDTH-1:0] up_out0;

    modport slave (
        input  start, ready, up_valid, up_done, up_out0,
        output valid, done, out0, out1, up_start, up_ready
    );

    modport master (
        output start, ready, up_valid, up_done, up_out0,
        input  valid, done, out0, out1, up_start, up_ready
    );
endinterface

// File: rtl/gen_window_sum.sv
// Generator-style consumer: restarts an upstream generator, folds its sample stream
// into a sliding-window sum and emits (window sum, samples accepted) tuples.
module gen_window_sum #(
    parameter int WIDTH  = 32,
    parameter int WINDOW = 3
) (
    input logic             _clock,
    input logic             _reset,
    gen_window_sum_if.slave bus
);
    localparam logic [0:0] ST_DONE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]       state_r;
    logic             valid_r;
    logic             done_r;
    logic             up_start_r;
    logic [WIDTH-1:0] out0_r;
    logic [WIDTH-1:0] out1_r;
    logic [WIDTH-1:0] sum_r;
    logic [WIDTH-1:0] cnt_r;
    logic [WIDTH-1:0] win_r [WINDOW];

    logic             up_ready_s;
    logic             accept_s;
    logic             consumed_s;
    logic             drain_s;
    logic             full_s;
    logic [WIDTH-1:0] sum_next_s;
    logic [WIDTH-1:0] cnt_next_s;

    function automatic logic [WIDTH-1:0] slide_sum(
        input logic [WIDTH-1:0] sum,
        input logic [WIDTH-1:0] x,
        input logic [WIDTH-1:0] oldest
    );
        return sum + x - oldest;
    endfunction

    // Handshake decode and next window sum; the last window slot is still zero until the window fills.
    always_comb begin
        up_ready_s = (state_r == ST_RUN) && !up_start_r && (!valid_r || bus.ready);
        accept_s   = bus.up_valid && up_ready_s;
        consumed_s = valid_r && bus.ready;
        drain_s    = !valid_r || bus.ready;
        sum_next_s = slide_sum(sum_r, bus.up_out0, win_r[WINDOW-1]);
        cnt_next_s = cnt_r + WIDTH'(1);
        full_s     = (cnt_next_s >= WIDTH'(WINDOW));
    end

    assign bus.valid    = valid_r;
    assign bus.done     = done_r;
    assign bus.out0     = out0_r;
    assign bus.out1     = out1_r;
    assign bus.up_start = up_start_r;
    assign bus.up_ready = up_ready_s;

    // Stream state, window and output tuple registers.
    always_ff @(posedge _clock or negedge _reset) begin
        if (!_reset) begin
            state_r    <= ST_DONE;
            valid_r    <= 1'b0;
            done_r     <= 1'b0;
            up_start_r <= 1'b0;
            out0_r     <= '0;
            out1_r     <= '0;
            sum_r      <= '0;
            cnt_r      <= '0;
            for (int i = 0; i < WINDOW; i++) begin
                win_r[i] <= '0;
            end
        end else if (bus.start) begin
            // A restart discards any tuple in flight and re-arms the upstream generator.
            state_r    <= ST_RUN;
            valid_r    <= 1'b0;
            done_r     <= 1'b0;
            up_start_r <= 1'b1;
            sum_r      <= '0;
            cnt_r      <= '0;
            for (int i = 0; i < WINDOW; i++) begin
                win_r[i] <= '0;
            end
        end else begin
            up_start_r <= 1'b0;
            case (state_r)
                ST_RUN: begin
                    if (accept_s) begin
                        win_r[0] <= bus.up_out0;
                        for (int i = WINDOW - 1; i > 0; i--) begin
                            win_r[i] <= win_r[i-1];
                        end
                        sum_r <= sum_next_s;
                        cnt_r <= cnt_next_s;
                        if (full_s) begin
                            out0_r  <= sum_next_s;
                            out1_r  <= cnt_next_s;
                            valid_r <= 1'b1;
                        end else if (consumed_s) begin
                            valid_r <= 1'b0;
                        end else begin
                            valid_r <= valid_r;
                        end
                    end else begin
                        if (consumed_s) begin
                            valid_r <= 1'b0;
                        end else begin
                            valid_r <= valid_r;
                        end
                        // up_done may still be stale from the previous stream while up_start is high.
                        if (!up_start_r && bus.up_done) begin
                            state_r <= ST_DONE;
                        end else begin
                            state_r <= ST_RUN;
                        end
                    end
                end
                ST_DONE: begin
                    if (drain_s) begin
                        valid_r <= 1'b0;
                        done_r  <= 1'b1;
                    end else begin
                        valid_r <= valid_r;
                        done_r  <= done_r;
                    end
                end
                default: begin
                    state_r <= ST_DONE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_gen_window_sum.sv
// Randomized scoreboard bench for gen_window_sum: an upstream generator model feeds samples,
// a reference model precomputes window tuples per stream and a monitor checks each consumed tuple.
module tb_gen_window_sum;
    localparam int WIN = 3;

    typedef struct {
        logic [31:0] sum;
        logic [31:0] cnt;
    } tuple_t;

    logic clk;
    logic rst_n;

    gen_window_sum_if #(.WIDTH(32)) bus ();
    gen_window_sum_if #(.WIDTH(8))  bus8 ();

    gen_window_sum #(.WIDTH(32), .WINDOW(WIN)) dut (
        ._clock (clk),
        ._reset (rst_n),
        .bus    (bus)
    );

    gen_window_sum #(.WIDTH(8), .WINDOW(3)) dut8 (
        ._clock (clk),
        ._reset (rst_n),
        .bus    (bus8)
    );

    int tests = 0;
    int fails = 0;
    int p_ready = 100;
    int p_valid = 100;
    int force_low = 0;
    int consumed = 0;
    int starts = 0;
    int up_start_cnt = 0;

    tuple_t      exp_q[$];
    logic [31:0] stim[$];
    logic [31:0] next_stream[$];
    logic [31:0] up_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference model: every full window of the stream, summed with 32-bit wraparound.
    task automatic model_expect();
        tuple_t t;
        for (int n = WIN; n <= stim.size(); n++) begin
            t.sum = 32'd0;
            for (int k = n - WIN; k < n; k++) t.sum = t.sum + stim[k];
            t.cnt = 32'(n);
            exp_q.push_back(t);
        end
    endtask

    task automatic make_hrange(input int lo, input int hi, input int step);
        stim.delete();
        for (int v = lo; v < hi; v += step) stim.push_back(32'(v));
    endtask

    task automatic make_random(input int len);
        stim.delete();
        for (int i = 0; i < len; i++) stim.push_back($urandom);
    endtask

    task automatic start_stream();
        @(negedge clk);
        next_stream = stim;
        exp_q.delete();
        model_expect();
        bus.start = 1'b1;
        starts++;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            #3;
            if (bus.done && exp_q.size() == 0) break;
        end
        check({name, "_done"}, 64'(bus.done), 64'd1);
        check({name, "_valid_low"}, 64'(bus.valid), 64'd0);
        check({name, "_drained"}, 64'(exp_q.size()), 64'd0);
    endtask

    // Caller ready driver
    initial begin
        bus.ready = 1'b0;
        forever begin
            @(negedge clk);
            if (force_low > 0) begin
                bus.ready = 1'b0;
                force_low--;
            end else begin
                bus.ready = (int'($urandom_range(99)) < p_ready);
            end
        end
    end

    // Upstream generator model: loads its stream on up_start, pops a sample on each handshake
    initial begin
        bus.up_valid = 1'b0;
        bus.up_done  = 1'b1;
        bus.up_out0  = 32'd0;
        forever begin
            @(negedge clk);
            if (up_q.size() > 0) begin
                bus.up_valid = (int'($urandom_range(99)) < p_valid);
                bus.up_out0  = up_q[0];
                bus.up_done  = 1'b0;
            end else begin
                bus.up_valid = 1'b0;
                bus.up_out0  = $urandom;
                bus.up_done  = 1'b1;
            end
            #1;
            if (rst_n && bus.up_start) up_q = next_stream;
            else if (bus.up_valid && bus.up_ready) void'(up_q.pop_front());
        end
    end

    // Monitor: compares every consumed tuple with the scoreboard and checks stalls
    initial begin
        bit          stall;
        logic [31:0] st_o0;
        logic [31:0] st_o1;
        tuple_t      t;
        stall = 1'b0;
        forever begin
            @(negedge clk);
            #2;
            if (!rst_n) begin
                stall = 1'b0;
            end else begin
                if (bus.up_start) up_start_cnt++;
                if (stall) begin
                    check("hold_valid", 64'(bus.valid), 64'd1);
                    check("hold_out0", 64'(bus.out0), 64'(st_o0));
                    check("hold_out1", 64'(bus.out1), 64'(st_o1));
                end
                if (bus.valid && !bus.ready) check("backpressure_up_ready", 64'(bus.up_ready), 64'd0);
                if (bus.valid && bus.ready && !bus.start) begin
                    if (exp_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_tuple: got (%0d,%0d), expected none", bus.out0, bus.out1);
                    end else begin
                        t = exp_q.pop_front();
                        check("tuple_sum", 64'(bus.out0), 64'(t.sum));
                        check("tuple_cnt", 64'(bus.out1), 64'(t.cnt));
                    end
                    consumed++;
                end
                stall = bus.valid && !bus.ready && !bus.start;
                st_o0 = bus.out0;
                st_o1 = bus.out1;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1);
    end

    initial begin
        int          c0;
        int          n8;
        int          got8;
        logic [7:0]  o0;
        logic [7:0]  o1;
        rst_n = 1'b0;
        bus.start = 1'b0;
        bus8.start = 1'b0;
        bus8.ready = 1'b1;
        bus8.up_valid = 1'b0;
        bus8.up_done = 1'b0;
        bus8.up_out0 = 8'd0;
        o0 = 8'd0;
        o1 = 8'd0;

        repeat (3) @(negedge clk);
        #2;
        check("rst_valid", 64'(bus.valid), 64'd0);
        check("rst_done", 64'(bus.done), 64'd0);
        check("rst_out0", 64'(bus.out0), 64'd0);
        check("rst_out1", 64'(bus.out1), 64'd0);
        check("rst_up_start", 64'(bus.up_start), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #2;
        check("rst_release_done", 64'(bus.done), 64'd1);

        // T1: hrange(0,10,2), caller always ready
        p_ready = 100; p_valid = 100;
        make_hrange(0, 10, 2);
        start_stream();
        wait_done("t1", 200);

        // T2: same stream, caller stalls for 5 cycles once tuples appear
        make_hrange(0, 10, 2);
        start_stream();
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            #3;
            if (bus.valid) break;
        end
        check("t2_first_valid", 64'(bus.valid), 64'd1);
        force_low = 5;
        wait_done("t2", 200);

        // T3: too-short stream, then empty stream
        make_hrange(0, 4, 2);
        start_stream();
        wait_done("t3_short", 200);
        make_hrange(5, 5, 1);
        start_stream();
        wait_done("t3_empty", 6);

        // Randomized streams with random bubbles and backpressure
        for (int r = 0; r < 8; r++) begin
            make_random(int'($urandom_range(20)));
            p_ready = int'($urandom_range(100, 30));
            p_valid = int'($urandom_range(100, 30));
            start_stream();
            wait_done("rand", 2000);
        end

        // T5: restart right after the first tuple is consumed
        p_ready = 100; p_valid = 100;
        make_hrange(0, 10, 2);
        start_stream();
        c0 = consumed;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            #3;
            if (consumed > c0) break;
        end
        check("t5_first_consumed", 64'(consumed > c0), 64'd1);
        make_hrange(0, 10, 2);
        start_stream();
        wait_done("t5", 200);

        // T4: 8-bit instance wraps 100+100+100 to 44
        @(negedge clk);
        bus8.start = 1'b1;
        @(negedge clk);
        bus8.start = 1'b0;
        bus8.up_valid = 1'b1;
        bus8.up_out0 = 8'd100;
        n8 = 0;
        got8 = 0;
        for (int k = 0; k < 20; k++) begin
            if (k > 0) @(negedge clk);
            if (n8 == 3) begin
                bus8.up_valid = 1'b0;
                bus8.up_done = 1'b1;
            end
            #1;
            if (bus8.up_valid && bus8.up_ready) n8++;
            if (bus8.valid && bus8.ready) begin
                got8++;
                o0 = bus8.out0;
                o1 = bus8.out1;
            end
        end
        check("t4_tuples", 64'(got8), 64'd1);
        check("t4_sum_wrap", 64'(o0), 64'd44);
        check("t4_cnt", 64'(o1), 64'd3);
        check("t4_done", 64'(bus8.done), 64'd1);

        // T6: asynchronous reset between clock edges mid-stream
        p_ready = 100; p_valid = 50;
        make_hrange(0, 40, 2);
        start_stream();
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            #3;
            if (bus.valid) break;
        end
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_valid", 64'(bus.valid), 64'd0);
        check("t6_done", 64'(bus.done), 64'd0);
        check("t6_out0", 64'(bus.out0), 64'd0);
        check("t6_out1", 64'(bus.out1), 64'd0);
        check("t6_up_ready", 64'(bus.up_ready), 64'd0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #2;
        check("t6_release_done", 64'(bus.done), 64'd1);
        repeat (5) @(negedge clk);
        #2;
        check("t6_no_restart", 64'(bus.up_start), 64'd0);
        check("t6_stay_done", 64'(bus.done), 64'd1);

        check("up_start_pulses", 64'(up_start_cnt), 64'(starts));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
